// File: rtl/uart_tx_fifo_if.sv
// Byte write channel into the UART transmitter FIFO.
// Latency: none; this is a plain signal bundle.
// Backpressure: a write happens only on a clk edge where i_tx_dv and o_tx_ready are both high.
interface uart_tx_fifo_if;
  logic       i_tx_dv;
  logic [7:0] i_tx_byte;
  logic       o_tx_ready;

  modport master (output i_tx_dv, output i_tx_byte, input o_tx_ready);
  modport slave  (input i_tx_dv, input i_tx_byte, output o_tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO. Frames are 8 data bits, optional parity, and 1 or 2 stop bits.
// Latency: a byte written into an empty FIFO while idle drives the start bit from the next edge.
// Backpressure: o_tx_ready drops while the FIFO is full, and writes made while full are dropped.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  uart_tx_fifo_if.slave                 tx,
  output logic                          o_tx_s,
  output logic                          o_tx_active,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage. The pointers are one bit wider than the address so that full and empty can be told apart.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        full;
  logic        empty;
  logic        wr_en;
  logic        pop;

  // Transmitter state.
  state_t      state;
  state_t      state_n;
  logic [CW-1:0] baud;
  logic [CW-1:0] baud_n;
  logic [2:0]  bit_idx;
  logic [2:0]  bit_idx_n;
  logic [7:0]  data;
  logic [7:0]  data_n;
  logic        tx_s_n;
  logic        active_n;
  logic        done_n;
  logic        bit_end;
  logic        par_bit;

  assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty        = (wptr == rptr);
  assign tx.o_tx_ready = ~full;
  assign wr_en        = tx.i_tx_dv && !full;
  assign o_fifo_count = wptr - rptr;
  assign bit_end      = (baud == CW'(CLKS_PER_BIT - 1));
  // Even parity is the XOR of the data bits. Odd parity is that value inverted.
  assign par_bit      = (^data) ^ (PARITY == 2);

  // Write the FIFO storage. This has no reset because the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= tx.i_tx_byte;
  end

  // Update the FIFO pointers. A write and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
    end
  end

  // Transmitter registers. The line output is registered, and reset returns the line high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      baud        <= '0;
      bit_idx     <= '0;
      data        <= '0;
      o_tx_s      <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
    end else begin
      state       <= state_n;
      baud        <= baud_n;
      bit_idx     <= bit_idx_n;
      data        <= data_n;
      o_tx_s      <= tx_s_n;
      o_tx_active <= active_n;
      o_tx_done   <= done_n;
    end
  end

  // Next-state and next-output logic for the frame sequencer.
  // Each register drives the value the line must show during the coming bit.
  always_comb begin
    state_n   = state;
    baud_n    = bit_end ? '0 : baud + CW'(1);
    bit_idx_n = bit_idx;
    data_n    = data;
    tx_s_n    = o_tx_s;
    active_n  = o_tx_active;
    done_n    = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        tx_s_n   = 1'b1;
        active_n = 1'b0;
        baud_n   = '0;
        if (!empty) begin
          pop       = 1'b1;
          data_n    = mem[rptr[AW-1:0]];
          tx_s_n    = 1'b0;
          active_n  = 1'b1;
          bit_idx_n = '0;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tx_s_n    = data[0];
          bit_idx_n = '0;
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            bit_idx_n = '0;
            if (PARITY != 0) begin
              tx_s_n  = par_bit;
              state_n = S_PARITY;
            end else begin
              tx_s_n  = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_s_n    = data[bit_idx + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_s_n    = 1'b1;
          bit_idx_n = '0;
          state_n   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx == 3'(STOP_BITS - 1)) begin
            done_n = 1'b1;
            if (!empty) begin
              // Start the next frame at this edge so there is no idle gap.
              pop       = 1'b1;
              data_n    = mem[rptr[AW-1:0]];
              tx_s_n    = 1'b0;
              bit_idx_n = '0;
              state_n   = S_START;
            end else begin
              tx_s_n   = 1'b1;
              active_n = 1'b0;
              state_n  = S_IDLE;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        state_n  = S_IDLE;
        tx_s_n   = 1'b1;
        active_n = 1'b0;
        baud_n   = '0;
      end
    endcase
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter with a small input FIFO; the transmit-side counterpart of the team's uart_rx.
- Accepts bytes from the system side over a valid/ready interface and serialises them as 8-N-1 frames (optional parity, 1 or 2 stop bits) on a single line.
- Frames use the same bit timing as the receiver (CLKS_PER_BIT clocks per bit), so a uart_tx_fifo output looped into uart_rx returns the same bytes.

Parameters:
- CLKS_PER_BIT, 87: clocks per serial bit; must be ≥ 2.
- FIFO_DEPTH, 4: entries in the byte FIFO; must be a power of 2, ≥ 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_tx_dv  input  1  byte-valid strobe; a write occurs on a clk edge where i_tx_dv=1 and o_tx_ready=1.
- i_tx_byte  input  8  byte to transmit; sampled on write.
- o_tx_ready  output  1  FIFO not full.
- o_tx_s  output  1  serial line; idles high; registered.
- o_tx_active  output  1  high while a frame (start through last stop bit) is on the line.
- o_tx_done  output  1  one-cycle pulse after the last stop bit of each frame.
- o_fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being sent.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - o_tx_s=1; o_tx_active=0; o_tx_done=0; o_fifo_count=0; o_tx_ready=1.
  - FIFO pointers cleared; FSM forced to IDLE.
  - A frame in flight is abandoned; the line returns high immediately.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address.
  - o_tx_ready = ~full, combinational from pointers.
  - Write while full is ignored; no overwrite.
  - Simultaneous write and pop in one cycle is legal when not full; the count is unchanged.
  - When full, the write is dropped even if a pop occurs in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx_s=1, o_tx_active=0.
  - If FIFO non-empty: pop the head into the shift register, drive o_tx_s=0, set o_tx_active=1, clear the bit counter, go to START.
  - A byte written at edge k into an empty FIFO while IDLE gives o_tx_s=0 from edge k+1.
- START: hold 0 for CLKS_PER_BIT clocks total, then drive data bit 0 and go to DATA.
- DATA:
  - Each bit held CLKS_PER_BIT clocks; LSB first; bit index 0..7.
  - After bit 7: go to PARITY if PARITY≠0, else drive 1 and go to STOP.
- PARITY:
  - Bit value = XOR of the 8 data bits; inverted when PARITY=2.
  - Held CLKS_PER_BIT clocks, then drive 1 and go to STOP.
- STOP:
  - Line held 1 for STOP_BITS×CLKS_PER_BIT clocks.
  - On the last clock: o_tx_done=1 for exactly that one following cycle.
  - If FIFO non-empty: pop and enter START with o_tx_s=0 at the same edge. Back-to-back frames have no idle gap and o_tx_active stays high.
  - Else go to IDLE; o_tx_active=0.
- Frame length: (1+8+(PARITY≠0)+STOP_BITS)×CLKS_PER_BIT clocks exactly.
- Baud counter width: $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary.
- The byte being shifted is held in a local register; FIFO writes during a frame never disturb it.
- Illegal state encodings return to IDLE with o_tx_s=1.

Test Plan:
- Bench settings: CLKS_PER_BIT=8, PARITY=0, STOP_BITS=1 unless noted.
- Single byte: write 0xA5 once → o_tx_s low 1 cycle after write; bits 1,0,1,0,0,1,0,1 each 8 clocks; stop high 8 clocks; o_tx_done pulses at clock 80; loopback uart_rx (CLKS_PER_BIT=8) reports 0xA5.
- Burst/full: write 0x01..0x06 on consecutive cycles with FIFO_DEPTH=4:
  - First byte popped immediately; 0x02–0x05 queued.
  - o_tx_ready=0 when count=4; 0x06 dropped.
  - Line sends 0x01–0x05 back-to-back, 400 clocks total with no idle gap; exactly 5 o_tx_done pulses.
- Parity: PARITY=1 with byte 0x07 → parity bit 1; PARITY=2 with byte 0x07 → parity bit 0; frame 88 clocks.
- Two stop bits: STOP_BITS=2 with byte 0x00 → line high 16 clocks after bit 7 before o_tx_done.
- Reset mid-frame: assert rst_n=0 during bit 3 of 0x3C with 2 bytes queued → o_tx_s=1 asynchronously; count=0; after release no frame starts until a new write.
- Simultaneous write and pop: write on the same edge a STOP ends with count=1 → next byte starts; count stays 1; written byte sent next.
